barrel_shift: RTL and testbench
===============================

Name: barrel_shift

Overview:
- 32-bit logical barrel shifter for the processor datapath.
- Shifts operand `a` left or right by 0-31 positions.
- Shift amount arrives as five discrete bits `b4..b0`; `r` selects direction.
- Result is registered: one-cycle latency, asynchronous active-low reset.

Parameters:
- RESET_VALUE, 32'h0000_0000, value loaded into `g` while reset is asserted.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- a  input  32  data operand to be shifted
- b4  input  1  shift-amount bit 4 (weight 16)
- b3  input  1  shift-amount bit 3 (weight 8)
- b2  input  1  shift-amount bit 2 (weight 4)
- b1  input  1  shift-amount bit 1 (weight 2)
- b0  input  1  shift-amount bit 0 (weight 1)
- r  input  1  direction: 1 = shift right, 0 = shift left
- g  output  32  registered shift result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Shift amount: `sh = {b4,b3,b2,b1,b0}`, unsigned, range 0..31.
- Combinational core, five cascaded mux stages, one per amount bit:
  - stage k shifts by 2^k when its bit is 1, otherwise passes through unchanged;
  - stage order is free, since the result is independent of order.
- Logical shifts only:
  - right shift fills vacated MSBs with 0 (no sign extension);
  - left shift fills vacated LSBs with 0;
  - bits shifted out are discarded; no rotate, no carry/overflow output.
- Direction applies to all stages uniformly.
  - Implementation choice: either direction-aware stages, or bit-reverse → shift-right → bit-reverse.
- Output register:
  - on each rising clock edge with `rst_n` = 1, `g` <= shift result of the current `a`, `sh` and `r`;
  - latency exactly 1 cycle from input change to `g` update;
  - full throughput: a new operation every cycle, no handshake or valid signals.
- Reset:
  - `rst_n` = 0 forces `g` = RESET_VALUE immediately, independent of clock;
  - `g` holds RESET_VALUE while `rst_n` is low;
  - first capture is on the first rising edge after `rst_n` goes high.
  - Reset asserted mid-stream: pending result is discarded and `g` clears at once.
- Boundary conditions:
  - `sh` = 0: `g` = `a` for either direction;
  - `sh` = 31: only `a[31]` survives at bit 0 (right) or `a[0]` at bit 31 (left);
  - shift by ≥ 32 is impossible by width.
- Inputs may change at any time between edges; only values at the rising edge matter.
- No internal state besides the 32-bit output register.

Test Plan:
- Reset: `rst_n`=0 with `a`=32'hFFFF_FFFF, `sh`=0 → `g`=0 without a clock edge; release reset, next edge → `g`=32'hFFFF_FFFF.
- Right shifts, one value per cycle, each appearing one edge after apply:
  - `a`=15, r=1, `sh`=16 (b4=1) → `g`=0;
  - `a`=33, r=1, `sh`=2 (b1=1) → `g`=8;
  - `a`=34, r=1, `sh`=4 (b2=1) → `g`=2.
- Logical fill:
  - `a`=32'h8000_0000, r=1, `sh`=31 → `g`=32'h0000_0001;
  - `a`=32'h8000_0001, r=1, `sh`=1 → `g`=32'h4000_0000.
- Left shift:
  - `a`=15, r=0, `sh`=16 → `g`=32'h000F_0000;
  - `a`=32'h0000_0001, r=0, `sh`=31 → `g`=32'h8000_0000;
  - `a`=32'hF000_0000, r=0, `sh`=4 → `g`=0.
- Zero shift and full sweep:
  - `sh`=0 with r=0 and r=1 → `g`=`a`;
  - sweep `sh`=0..31 on `a`=32'hA5A5_A5A5 in both directions, compared against the golden `>>`/`<<` result one cycle later.
- Mid-stream reset: assert `rst_n`=0 between edges during back-to-back operations → `g`=0 immediately; resumes correct results one edge after release.

Source files
------------

// File: rtl/barrel_shift.sv
// rtl/barrel_shift.sv - 32-bit logical barrel shifter with registered result
module barrel_shift #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic        b4,
    input  logic        b3,
    input  logic        b2,
    input  logic        b1,
    input  logic        b0,
    input  logic        r,
    output logic [31:0] g
);

    // Left shifts are done as reverse -> shift right -> reverse, so only one
    // set of right-shifting mux stages is needed for both directions.
    logic [31:0] pre_rev;
    logic [31:0] stage_1;
    logic [31:0] stage_2;
    logic [31:0] stage_4;
    logic [31:0] stage_8;
    logic [31:0] stage_16;
    logic [31:0] post_rev;
    logic [31:0] g_d;
    logic [31:0] g_q;

    // Bit-reverse the operand on the way in when shifting left
    always_comb begin
        pre_rev = '0;
        for (int i = 0; i < 32; i++) begin
            pre_rev[i] = r ? a[i] : a[31 - i];
        end
    end

    // Five cascaded logical right-shift stages, zero fill, one per amount bit
    always_comb begin
        stage_1  = b0 ? {1'b0,  pre_rev[31:1]}  : pre_rev;
        stage_2  = b1 ? {2'b0,  stage_1[31:2]}  : stage_1;
        stage_4  = b2 ? {4'b0,  stage_2[31:4]}  : stage_2;
        stage_8  = b3 ? {8'b0,  stage_4[31:8]}  : stage_4;
        stage_16 = b4 ? {16'b0, stage_8[31:16]} : stage_8;
    end

    // Undo the input reversal for left shifts and form the next register value
    always_comb begin
        post_rev = '0;
        for (int i = 0; i < 32; i++) begin
            post_rev[i] = r ? stage_16[i] : stage_16[31 - i];
        end
        g_d = post_rev;
    end

    // Result register; reset discards any pending result immediately
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= RESET_VALUE;
        end else begin
            g_q <= g_d;
        end
    end

    assign g = g_q;

endmodule

// File: tb/tb_barrel_shift.sv
// tb/tb_barrel_shift.sv - self-checking bench for barrel_shift
module tb_barrel_shift;

    logic        clock;
    logic        rst_n;
    logic [31:0] a;
    logic        b4, b3, b2, b1, b0;
    logic        r;
    logic [31:0] g;

    int n_checks = 0;
    int n_errors = 0;

    barrel_shift #(.RESET_VALUE(32'h0000_0000)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .a     (a),
        .b4    (b4),
        .b3    (b3),
        .b2    (b2),
        .b1    (b1),
        .b0    (b0),
        .r     (r),
        .g     (g)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] av, input int sh, input logic rv);
        if (rv) return av >> sh;
        return av << sh;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [4:0] sh, input logic rv);
        a = av;
        {b4, b3, b2, b1, b0} = sh;
        r = rv;
    endtask

    // Drive one operation, clock it in, then compare one edge later
    task automatic op(input string tag, input logic [31:0] av, input logic [4:0] sh,
                      input logic rv, input logic [31:0] exp);
        drive(av, sh, rv);
        @(posedge clock);
        #1;
        check(tag, g, exp);
    endtask

    task automatic op_model(input string tag, input logic [31:0] av, input logic [4:0] sh, input logic rv);
        op(tag, av, sh, rv, ref_shift(av, int'(sh), rv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [4:0]  rsh;
        logic        rr;

        rst_n = 1'b1;
        drive(32'hFFFF_FFFF, 5'd0, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("reset_async", g, 32'h0);
        @(posedge clock);
        #1 check("reset_hold", g, 32'h0);
        rst_n = 1'b1;
        @(posedge clock);
        #1 check("reset_release", g, 32'hFFFF_FFFF);

        op("right_15_16",   32'd15,          5'd16, 1'b1, 32'd0);
        op("right_33_2",    32'd33,          5'd2,  1'b1, 32'd8);
        op("right_34_4",    32'd34,          5'd4,  1'b1, 32'd2);
        op("right_fill_31", 32'h8000_0000,   5'd31, 1'b1, 32'h0000_0001);
        op("right_fill_1",  32'h8000_0001,   5'd1,  1'b1, 32'h4000_0000);
        op("left_15_16",    32'd15,          5'd16, 1'b0, 32'h000F_0000);
        op("left_1_31",     32'h0000_0001,   5'd31, 1'b0, 32'h8000_0000);
        op("left_f_4",      32'hF000_0000,   5'd4,  1'b0, 32'h0);
        op("right_msb_31",  32'h7FFF_FFFF,   5'd31, 1'b1, 32'h0);
        op("left_lsb_31",   32'hFFFF_FFFE,   5'd31, 1'b0, 32'h0);
        op("zero_left",     32'h1234_5678,   5'd0,  1'b0, 32'h1234_5678);
        op("zero_right",    32'h9ABC_DEF0,   5'd0,  1'b1, 32'h9ABC_DEF0);

        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 32; s++) begin
                op_model($sformatf("sweep_r%0d_sh%0d", d, s), 32'hA5A5_A5A5, 5'(s), 1'(d));
            end
        end

        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            rr  = 1'($urandom_range(0, 1));
            op_model($sformatf("rand_%0d", i), ra, rsh, rr);
        end

        op_model("pre_midreset_0", 32'hDEAD_BEEF, 5'd3, 1'b0);
        drive(32'hCAFE_F00D, 5'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("midreset_async", g, 32'h0);
        @(posedge clock);
        #1 check("midreset_hold", g, 32'h0);
        rst_n = 1'b1;
        op_model("post_midreset_0", 32'hCAFE_F00D, 5'd7, 1'b1);
        op_model("post_midreset_1", 32'h0F0F_0F0F, 5'd9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
